// File: rtl/mest_pro_pkg.sv
// rtl/mest_pro_pkg.sv - opcode/state enums and instruction field helpers for the mest_pro core
package mest_pro_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_JMP  = 4'h8,
        OP_JZ   = 4'h9,
        OP_JC   = 4'hA,
        OP_CALL = 4'hB,
        OP_RET  = 4'hC,
        OP_END  = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_DONE,
        S_HOLD
    } state_e;

    // Instruction layout {op, K, A, B}; field LSBs depend on the core's PC/data widths.
    function automatic int instr_width(input int pc_w, input int data_w);
        return OP_W + pc_w + 2 * data_w;
    endfunction

    function automatic int op_lsb(input int pc_w, input int data_w);
        return pc_w + 2 * data_w;
    endfunction

    function automatic int k_lsb(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int a_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_SHR);
    endfunction

endpackage

// File: rtl/mest_pro_call_stack.sv
// rtl/mest_pro_call_stack.sv - LIFO of return addresses with full/empty status
module mest_pro_call_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_m1;

    assign sp_m1 = sp - 1'b1;
    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);
    assign top   = mem[sp_m1[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp_m1;
        end
    end

    // Entries need no reset: they are only read below a valid stack pointer.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mest_pro_gen2.sv
// rtl/mest_pro_gen2.sv - multi-cycle processor core; MEST_PRO_STEP_EN adds single-step HOLD
module mest_pro_gen2
    import mest_pro_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ROM_DEPTH   = 16,
    parameter int STACK_DEPTH = 4,
    localparam int PC_W       = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1,
    localparam int INSTR_W    = OP_W + PC_W + 2 * DATA_W
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_start,
    output logic               o_req,
    output logic [PC_W-1:0]    o_prog_counter,
    input  logic               i_instr_valid,
    input  logic [INSTR_W-1:0] i_instruction,
    output logic [DATA_W-1:0]  o_result,
    output logic               o_valid_result,
    output logic               o_carry,
    output logic               o_zero_flag,
    output logic               o_error,
`ifdef MEST_PRO_STEP_EN
    input  logic               i_step,
    output logic               o_hold,
`endif
    output logic               o_all_done
);

    localparam int OP_LSB = op_lsb(PC_W, DATA_W);
    localparam int K_LSB  = k_lsb(DATA_W);
    localparam int A_LSB  = a_lsb(DATA_W);
    localparam logic [PC_W:0] DEPTH_EXT = (PC_W + 1)'(ROM_DEPTH);

    state_e              state;
    logic [PC_W-1:0]     pc;
    logic [INSTR_W-1:0]  instr_q;
    logic [OP_W-1:0]     op_q;
    logic [PC_W-1:0]     k_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;

    logic [PC_W-1:0]     k_raw;
    logic [PC_W-1:0]     pc_next;
    logic [PC_W-1:0]     exec_pc;
    logic [DATA_W-1:0]   alu_r;
    logic                alu_c;
    logic                exec_err;
    logic                exec_stop;

    logic                stk_push;
    logic                stk_pop;
    logic                stk_clear;
    logic [PC_W-1:0]     stk_top;
    logic                stk_full;
    logic                stk_empty;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
        return (p == PC_W'(ROM_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_prog_counter = pc;
    assign pc_next        = pc_inc(pc);
    assign k_raw          = instr_q[K_LSB +: PC_W];

    assign stk_clear = ((state == S_IDLE) || (state == S_DONE)) && i_start;
    assign stk_push  = (state == S_EXECUTE) && (op_q == OP_CALL) && !stk_full;
    assign stk_pop   = (state == S_EXECUTE) && (op_q == OP_RET) && !stk_empty;

    mest_pro_call_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_call_stack (
        .clk       (clk),
        .reset     (i_reset),
        .clear     (stk_clear),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_next),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Carry is bit DATA_W of the widened op; for SUB that bit is the borrow.
    always_comb begin
        {alu_c, alu_r} = {1'b0, a_q};
        case (op_q)
            OP_ADD:  {alu_c, alu_r} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  {alu_c, alu_r} = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:  {alu_c, alu_r} = {1'b0, a_q & b_q};
            OP_OR:   {alu_c, alu_r} = {1'b0, a_q | b_q};
            OP_XOR:  {alu_c, alu_r} = {1'b0, a_q ^ b_q};
            OP_SHL:  {alu_c, alu_r} = {a_q[DATA_W-1], a_q[DATA_W-2:0], 1'b0};
            OP_SHR:  {alu_c, alu_r} = {a_q[0], 1'b0, a_q[DATA_W-1:1]};
            default: {alu_c, alu_r} = {1'b0, a_q};
        endcase
    end

    always_comb begin
        exec_pc  = pc_next;
        exec_err = 1'b0;
        case (op_q)
            OP_JMP:  exec_pc = k_q;
            OP_JZ:   exec_pc = o_zero_flag ? k_q : pc_next;
            OP_JC:   exec_pc = o_carry ? k_q : pc_next;
            OP_CALL: begin
                exec_pc  = stk_full ? pc : k_q;
                exec_err = stk_full;
            end
            OP_RET: begin
                exec_pc  = stk_empty ? pc : stk_top;
                exec_err = stk_empty;
            end
            4'hD, 4'hE: exec_err = 1'b1;
            default: exec_pc = pc_next;
        endcase
        exec_stop = exec_err || (op_q == OP_END);
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state          <= S_IDLE;
            pc             <= '0;
            instr_q        <= '0;
            op_q           <= '0;
            k_q            <= '0;
            a_q            <= '0;
            b_q            <= '0;
            o_req          <= 1'b0;
            o_result       <= '0;
            o_valid_result <= 1'b0;
            o_carry        <= 1'b0;
            o_zero_flag    <= 1'b0;
            o_error        <= 1'b0;
            o_all_done     <= 1'b0;
`ifdef MEST_PRO_STEP_EN
            o_hold         <= 1'b0;
`endif
        end else begin
            o_valid_result <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        pc    <= '0;
                        o_req <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (o_req && i_instr_valid) begin
                        instr_q <= i_instruction;
                        o_req   <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_q  <= instr_q[OP_LSB +: OP_W];
                    k_q   <= ({1'b0, k_raw} >= DEPTH_EXT) ? PC_W'({1'b0, k_raw} - DEPTH_EXT) : k_raw;
                    a_q   <= instr_q[A_LSB +: DATA_W];
                    b_q   <= instr_q[0 +: DATA_W];
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (is_alu_op(op_q)) begin
                        o_result       <= alu_r;
                        o_carry        <= alu_c;
                        o_zero_flag    <= (alu_r == '0);
                        o_valid_result <= 1'b1;
                    end
                    pc <= exec_pc;
                    if (exec_stop) begin
                        o_error    <= o_error | exec_err;
                        o_all_done <= 1'b1;
                        state      <= S_DONE;
                    end else begin
`ifdef MEST_PRO_STEP_EN
                        o_hold <= 1'b1;
                        state  <= S_HOLD;
`else
                        o_req  <= 1'b1;
                        state  <= S_FETCH;
`endif
                    end
                end
`ifdef MEST_PRO_STEP_EN
                S_HOLD: begin
                    if (i_step) begin
                        o_hold <= 1'b0;
                        o_req  <= 1'b1;
                        state  <= S_FETCH;
                    end
                end
`endif
                S_DONE: begin
                    if (i_start) begin
                        pc         <= '0;
                        o_error    <= 1'b0;
                        o_all_done <= 1'b0;
                        o_req      <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                default: begin
                    o_req <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mest_pro_gen2.sv
// tb/tb_mest_pro_gen2.sv - scoreboard bench for mest_pro_gen2 with a wait-state ROM model
module tb_mest_pro_gen2;

    localparam int DW = 8;
    localparam int RD = 16;
    localparam int SD = 2;
    localparam int PW = 4;
    localparam int IW = 4 + PW + 2 * DW;

    typedef struct {
        logic [DW-1:0] r;
        logic          c;
        logic          z;
    } res_t;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_start = 1'b0;
    logic          o_req;
    logic [PW-1:0] o_prog_counter;
    logic          i_instr_valid = 1'b0;
    logic [IW-1:0] i_instruction = '0;
    logic [DW-1:0] o_result;
    logic          o_valid_result;
    logic          o_carry;
    logic          o_zero_flag;
    logic          o_error;
    logic          o_all_done;
`ifdef MEST_PRO_STEP_EN
    logic          i_step = 1'b0;
    logic          o_hold;
`endif

    int checks = 0;
    int failures = 0;

    logic [IW-1:0] rom [RD];
    bit            fetched [RD];
    int            wait_cycles = 0;
    res_t          exp_q [$];
    bit            done_q [$];
    bit            done_seen = 1'b0;

    always #5 clk = ~clk;

    mest_pro_gen2 #(
        .DATA_W      (DW),
        .ROM_DEPTH   (RD),
        .STACK_DEPTH (SD)
    ) dut (
        .clk            (clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .o_req          (o_req),
        .o_prog_counter (o_prog_counter),
        .i_instr_valid  (i_instr_valid),
        .i_instruction  (i_instruction),
        .o_result       (o_result),
        .o_valid_result (o_valid_result),
        .o_carry        (o_carry),
        .o_zero_flag    (o_zero_flag),
        .o_error        (o_error),
`ifdef MEST_PRO_STEP_EN
        .i_step         (i_step),
        .o_hold         (o_hold),
`endif
        .o_all_done     (o_all_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [3:0] k,
                                         input logic [7:0] a, input logic [7:0] b);
        return {op, k, a, b};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < RD; i++) rom[i] = mk(4'hF, 4'h0, 8'h00, 8'h00);
    endtask

    task automatic expect_res(input logic [7:0] r, input logic c, input logic z);
        res_t e;
        e.r = r; e.c = c; e.z = z;
        exp_q.push_back(e);
    endtask

    // ROM: answers o_req after wait_cycles idle cycles; address must hold meanwhile.
    initial begin
        int cnt;
        logic [PW-1:0] held_pc;
        cnt = 0;
        held_pc = '0;
        forever begin
            @(negedge clk);
            if (o_req && !i_reset) begin
                if (cnt == 0) held_pc = o_prog_counter;
                else chk("pc_stable", {28'd0, o_prog_counter}, {28'd0, held_pc});
                if (cnt >= wait_cycles) begin
                    i_instr_valid = 1'b1;
                    i_instruction = rom[o_prog_counter];
                    fetched[o_prog_counter] = 1'b1;
                    cnt = 0;
                end else begin
                    i_instr_valid = 1'b0;
                    cnt++;
                end
            end else begin
                i_instr_valid = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: each result pulse and each DONE entry consumes one expectation.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!i_reset) begin
                if (o_valid_result) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", {24'd0, o_result}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", {24'd0, o_result}, {24'd0, e.r});
                        chk("carry", {31'd0, o_carry}, {31'd0, e.c});
                        chk("zero", {31'd0, o_zero_flag}, {31'd0, e.z});
                    end
                end
                if (o_all_done && !done_seen) begin
                    done_seen = 1'b1;
                    if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                    else chk("error_at_done", {31'd0, o_error}, {31'd0, done_q.pop_front()});
                end
            end
            if (!o_all_done) done_seen = 1'b0;
        end
    end

    task automatic pulse_start();
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
    endtask

    task automatic run_prog(input string name, input int w, input int exp_cycles);
        int n;
        wait_cycles = w;
        for (int i = 0; i < RD; i++) fetched[i] = 1'b0;
        pulse_start();
        n = 0;
        while (!o_all_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, {31'd0, o_all_done}, 32'd1);
        chk({name, "_cycles"}, n, exp_cycles);
        @(negedge clk);
        chk({name, "_results_drained"}, exp_q.size(), 0);
        chk({name, "_done_drained"}, done_q.size(), 0);
    endtask

    initial begin
        clear_rom();
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        chk("rst_req", {31'd0, o_req}, 0);
        chk("rst_pc", {28'd0, o_prog_counter}, 0);
        chk("rst_result", {24'd0, o_result}, 0);
        chk("rst_flags", {28'd0, o_valid_result, o_carry, o_zero_flag, o_error}, 0);
        chk("rst_done", {31'd0, o_all_done}, 0);

        // ADD with carry out, then END: 2 instructions x 3 cycles
        clear_rom();
        rom[0] = mk(4'h1, 4'h0, 8'hF0, 8'h20);
        expect_res(8'h10, 1'b1, 1'b0);
        done_q.push_back(1'b0);
        run_prog("t1", 0, 6);

        // SUB to zero, JZ over two ADDs
        clear_rom();
        rom[0] = mk(4'h2, 4'h0, 8'h05, 8'h05);
        rom[1] = mk(4'h9, 4'h4, 8'h00, 8'h00);
        rom[2] = mk(4'h1, 4'h0, 8'h01, 8'h01);
        rom[3] = mk(4'h1, 4'h0, 8'h01, 8'h01);
        expect_res(8'h00, 1'b0, 1'b1);
        done_q.push_back(1'b0);
        run_prog("t2", 0, 9);
        chk("t2_skip2", {31'd0, fetched[2]}, 0);
        chk("t2_skip3", {31'd0, fetched[3]}, 0);
        chk("t2_end_fetched", {31'd0, fetched[4]}, 1);

        // 3 ROM wait states per fetch; ALU mix and taken JC
        clear_rom();
        rom[0] = mk(4'h1, 4'h0, 8'h12, 8'h34);
        rom[1] = mk(4'h6, 4'h0, 8'h81, 8'h00);
        rom[2] = mk(4'hA, 4'h4, 8'h00, 8'h00);
        rom[3] = mk(4'h1, 4'h0, 8'hFF, 8'h01);
        rom[4] = mk(4'h7, 4'h0, 8'h03, 8'h00);
        rom[5] = mk(4'h5, 4'h0, 8'hFF, 8'hFF);
        rom[6] = mk(4'h4, 4'h0, 8'hA0, 8'h05);
        expect_res(8'h46, 1'b0, 1'b0);
        expect_res(8'h02, 1'b1, 1'b0);
        expect_res(8'h01, 1'b1, 1'b0);
        expect_res(8'h00, 1'b0, 1'b1);
        expect_res(8'hA5, 1'b0, 1'b0);
        done_q.push_back(1'b0);
        run_prog("t3", 3, 42);
        chk("t3_skip3", {31'd0, fetched[3]}, 0);

        // Third nested CALL overflows a 2-deep stack
        clear_rom();
        rom[0] = mk(4'hB, 4'h4, 8'h00, 8'h00);
        rom[4] = mk(4'hB, 4'h8, 8'h00, 8'h00);
        rom[8] = mk(4'hB, 4'hC, 8'h00, 8'h00);
        done_q.push_back(1'b1);
        run_prog("t4a", 0, 9);
        chk("t4a_no_target", {31'd0, fetched[12]}, 0);

        // Restart clears error and SP; CALL/RET round trip
        clear_rom();
        rom[0] = mk(4'hB, 4'h3, 8'h00, 8'h00);
        rom[3] = mk(4'h1, 4'h0, 8'h02, 8'h03);
        rom[4] = mk(4'hC, 4'h0, 8'h00, 8'h00);
        expect_res(8'h05, 1'b0, 1'b0);
        done_q.push_back(1'b0);
        run_prog("t4b", 0, 12);

        // RET with empty stack
        clear_rom();
        rom[0] = mk(4'hC, 4'h0, 8'h00, 8'h00);
        done_q.push_back(1'b1);
        run_prog("t4c", 0, 3);

        // Reset while a fetch is outstanding, then rerun from PC 0
        clear_rom();
        rom[0] = mk(4'h1, 4'h0, 8'hF0, 8'h20);
        wait_cycles = 5;
        pulse_start();
        @(negedge clk);
        chk("t5_req_pending", {31'd0, o_req}, 1);
        i_reset = 1'b1;
        @(negedge clk);
        chk("t5_req", {31'd0, o_req}, 0);
        chk("t5_pc", {28'd0, o_prog_counter}, 0);
        chk("t5_outs", {23'd0, o_result, o_carry}, 0);
        chk("t5_done_err", {30'd0, o_all_done, o_error}, 0);
        i_reset = 1'b0;
        expect_res(8'h10, 1'b1, 1'b0);
        done_q.push_back(1'b0);
        run_prog("t5", 0, 6);

`ifdef MEST_PRO_STEP_EN
        // Single-step: one instruction per i_step pulse
        clear_rom();
        rom[0] = mk(4'h1, 4'h0, 8'h01, 8'h01);
        rom[1] = mk(4'h1, 4'h0, 8'h02, 8'h02);
        expect_res(8'h02, 1'b0, 1'b0);
        expect_res(8'h04, 1'b0, 1'b0);
        done_q.push_back(1'b0);
        wait_cycles = 0;
        pulse_start();
        repeat (10) @(negedge clk);
        chk("t6_hold0", {31'd0, o_hold}, 1);
        chk("t6_pending0", exp_q.size(), 1);
        chk("t6_notdone0", {31'd0, o_all_done}, 0);
        i_step = 1'b1;
        @(negedge clk) i_step = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_hold1", {31'd0, o_hold}, 1);
        chk("t6_pending1", exp_q.size(), 0);
        i_step = 1'b1;
        @(negedge clk) i_step = 1'b0;
        begin
            int n;
            n = 0;
            while (!o_all_done && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t6_done", {31'd0, o_all_done}, 1);
        chk("t6_hold_clear", {31'd0, o_hold}, 0);
        @(negedge clk);
        chk("t6_done_drained", done_q.size(), 0);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
